// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, registered read ports and
// destination reservation. Define REGFILE_BYPASS_EN to forward same-cycle writebacks to reads.
module regfile_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_ok,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [ADDR_W:0]          busy_cnt_q, busy_cnt_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic                     wr_fire, rsv_fire;
    logic [ADDR_W-1:0]        ra;

    assign wr_fire  = wr_en && (wr_addr != '0);
    // A busy register may still be granted when the same cycle's writeback releases it.
    assign rsv_ok   = (rsv_addr == '0) || !busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
    assign rsv_fire = rsv_en && rsv_ok && (rsv_addr != '0);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        mem_d = mem_q;
        if (wr_fire) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Reservation is applied after the writeback clear so it wins on a same-address collision.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_fire) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        ra        = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            if (rd_en[p]) begin
                if (ra == '0) begin
                    rd_data_d[p*DATA_W +: DATA_W] = '0;
                    rd_busy_d[p]                  = 1'b0;
                end else begin
`ifdef REGFILE_BYPASS_EN
                    rd_data_d[p*DATA_W +: DATA_W] = (wr_fire && (ra == wr_addr)) ? wr_data : mem_q[ra];
                    rd_busy_d[p]                  = busy_d[ra];
`else
                    rd_data_d[p*DATA_W +: DATA_W] = mem_q[ra];
                    rd_busy_d[p]                  = busy_q[ra];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register array is reset too, so reads after reset return 0 rather than X.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters),
// expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     rd_en = '0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              rsv_en = 1'b0;
    logic [AW-1:0]     rsv_addr = '0;
    logic              rsv_ok;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [NR-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    logic [DW-1:0] bypass_exp;

    initial begin
        #2 rst = 1'b0;
        tick();
        tick();
        check("reset_rd0", port_data(0), 64'h0);
        check("reset_rd1", port_data(1), 64'h0);
        check("reset_busy_cnt", busy_cnt, 0);
        check("reset_rd_busy", rd_busy, 0);
        rst = 1'b1;
        tick();

        // Write r5, then read it on both ports.
        wr_en = 1'b1; wr_addr = 5; wr_data = 64'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        set_rd(2'b11, 5, 5);
        tick();
        check("r5_port0", port_data(0), 64'hDEAD_BEEF);
        check("r5_port1", port_data(1), 64'hDEAD_BEEF);
        check("r5_not_busy", rd_busy, 0);

        // r0 discards writes.
        set_rd(2'b00, 0, 0);
        wr_en = 1'b1; wr_addr = 0; wr_data = 64'h1234;
        tick();
        wr_en = 1'b0;
        set_rd(2'b11, 0, 0);
        tick();
        check("r0_port0", port_data(0), 64'h0);
        check("r0_port1", port_data(1), 64'h0);

        // Disabled port holds its previous value.
        set_rd(2'b01, 5, 5);
        tick();
        check("hold_port0_read", port_data(0), 64'hDEAD_BEEF);
        check("hold_port1_kept", port_data(1), 64'h0);
        set_rd(2'b00, 0, 0);

        // Reserve r7; a second request is refused until r7 is written back.
        rsv_en = 1'b1; rsv_addr = 7;
        #1 check("rsv7_first_ok", rsv_ok, 1);
        tick();
        check("rsv7_cnt", busy_cnt, 1);
        check("rsv7_second_refused", rsv_ok, 0);
        tick();
        check("rsv7_refused_cnt", busy_cnt, 1);
        rsv_en = 1'b0;
        set_rd(2'b01, 7, 0);
        tick();
        check("r7_rd_busy", rd_busy[0], 1);
        set_rd(2'b00, 0, 0);
        wr_en = 1'b1; wr_addr = 7; wr_data = 64'h77;
        #1 check("r7_release_ok", rsv_ok, 1);
        tick();
        wr_en = 1'b0;
        #1;
        check("r7_free_cnt", busy_cnt, 0);
        check("r7_free_ok", rsv_ok, 1);

        // Same-cycle writeback and reservation of a busy register.
        rsv_en = 1'b1; rsv_addr = 9;
        tick();
        check("r9_busy_cnt", busy_cnt, 1);
        wr_en = 1'b1; wr_addr = 9; wr_data = 64'h55;
        #1 check("r9_sim_rsv_ok", rsv_ok, 1);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        check("r9_sim_cnt", busy_cnt, 1);
        set_rd(2'b10, 0, 9);
        tick();
        check("r9_sim_data", port_data(1), 64'h55);
        check("r9_sim_busy", rd_busy[1], 1);
        set_rd(2'b00, 0, 0);
        wr_en = 1'b1; wr_addr = 9; wr_data = 64'h55;
        tick();
        wr_en = 1'b0;
        check("r9_cleared_cnt", busy_cnt, 0);

        // Same-cycle write and read of r3.
        wr_en = 1'b1; wr_addr = 3; wr_data = 64'h11;
        tick();
        wr_data = 64'hAA;
        set_rd(2'b11, 3, 3);
        tick();
        wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 64'hAA;
`else
        bypass_exp = 64'h11;
`endif
        check("r3_same_cycle_p0", port_data(0), bypass_exp);
        check("r3_same_cycle_p1", port_data(1), bypass_exp);
        tick();
        check("r3_after_write", port_data(0), 64'hAA);
        set_rd(2'b00, 0, 0);

        // Fill the scoreboard.
        rsv_en = 1'b1;
        for (int a = 1; a < 32; a++) begin
            rsv_addr = AW'(a);
            tick();
        end
        rsv_en = 1'b0;
        check("full_cnt", busy_cnt, 31);
        for (int a = 1; a < 32; a++) begin
            rsv_addr = AW'(a);
            #1 check($sformatf("full_rsv_ok_r%0d", a), rsv_ok, 0);
        end
        rsv_addr = 0;
        #1 check("full_rsv_ok_r0", rsv_ok, 1);

        // Asynchronous reset in the middle of traffic.
        tick();
        wr_en = 1'b1; wr_addr = 12; wr_data = 64'hCAFE;
        set_rd(2'b11, 5, 3);
        rsv_en = 1'b1; rsv_addr = 4;
        #3 rst = 1'b0;
        #1;
        wr_en = 1'b0; rsv_en = 1'b0; set_rd(2'b00, 0, 0);
        #1;
        check("midrst_cnt", busy_cnt, 0);
        check("midrst_rd0", port_data(0), 64'h0);
        check("midrst_rd1", port_data(1), 64'h0);
        rsv_addr = 5;
        #1 check("midrst_ok_r5", rsv_ok, 1);
        rsv_addr = 31;
        #1 check("midrst_ok_r31", rsv_ok, 1);
        tick();
        rst = 1'b1;
        set_rd(2'b11, 5, 3);
        rsv_en = 1'b1; rsv_addr = 5;
        #1 check("post_rst_rsv_ok", rsv_ok, 1);
        tick();
        rsv_en = 1'b0; set_rd(2'b00, 0, 0);
        check("post_rst_r5_cleared", port_data(0), 64'h0);
        check("post_rst_r3_cleared", port_data(1), 64'h0);
        check("post_rst_cnt", busy_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
